serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 207 ++++++++++++++++++++
 tb/tb_serial_subtractor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor. An accepted start captures a and b. The
// block then spends WIDTH cycles in RUN, producing one difference bit per
// cycle, LSB first, through a single full-subtractor cell and a borrow flop.
// A one-cycle DONE state presents the result and can accept the next start
// directly, so operations can run back to back with no idle cycle.
//
// Optional feature:
//   `define SERIAL_SUBTRACTOR_OVF_EN  -> adds output ovf, the two's-complement
//                                        signed overflow of a - b.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..32), default 8
//
// Ports:
//   clk    input   1      single clock, rising edge
//   rst    input   1      synchronous, active-high reset
//   start  input   1      request a new subtraction (accepted in IDLE or DONE)
//   a      input   WIDTH  minuend, captured on an accepted start
//   b      input   WIDTH  subtrahend, captured on an accepted start
//   busy   output  1      high while in RUN
//   done   output  1      one-cycle pulse; diff/bout (and ovf) valid
//   diff   output  WIDTH  a - b modulo 2^WIDTH, held until next result
//   bout   output  1      final borrow, 1 iff a < b (unsigned)
//   ovf    output  1      signed overflow (only with SERIAL_SUBTRACTOR_OVF_EN)
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Counter only has to reach WIDTH-1.
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Operand shift registers (shift right, bit 0 consumed each RUN cycle).
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Result shift register, filled from the MSB end.
    logic [WIDTH-1:0] res_sr;
    logic             br_q;
    logic [CW-1:0]    cnt_q;

    // FSM control strobes.
    logic             load;
    logic             step;
    logic             last_bit;

    // Full-subtractor cell on the current bit pair.
    logic             bit_a;
    logic             bit_b;
    logic             bit_d;
    logic             br_next;
    logic [WIDTH-1:0] res_next;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    // Operand sign bits are shifted out of a_sr/b_sr during RUN, so they are
    // kept separately for the overflow decision at the end.
    logic             a_msb_q;
    logic             b_msb_q;
    logic             ovf_next;
`endif

    // -------------------------------------------------------------------------
    // Datapath combinational terms
    // -------------------------------------------------------------------------
    always_comb begin
        bit_a    = a_sr[0];
        bit_b    = b_sr[0];
        bit_d    = bit_a ^ bit_b ^ br_q;
        br_next  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
        res_next = {bit_d, res_sr[WIDTH-1:1]};
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    // bit_d on the last step is the MSB of the final difference.
    always_comb begin
        ovf_next = (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
    end
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        load    = 1'b0;
        step    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end

            RUN: begin
                // start is deliberately not looked at here.
                busy = 1'b1;
                step = 1'b1;
                if (last_bit) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                done = 1'b1;
                // A start here behaves as in IDLE, skipping the idle cycle.
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff    <= '0;
            bout    <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf     <= 1'b0;
`endif
        end else if (load) begin
            a_sr    <= a;
            b_sr    <= b;
            res_sr  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
`endif
        end else if (step) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            res_sr <= res_next;
            br_q   <= br_next;
            cnt_q  <= cnt_q + CW'(1);
            // Published results change only on the edge that enters DONE,
            // taking the final bit straight from the cell rather than waiting
            // a cycle for res_sr to settle.
            if (last_bit) begin
                diff <= res_next;
                bout <= br_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                ovf  <= ovf_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor (WIDTH = 8). Expected results come
// from plain integer arithmetic on the operands: a - b modulo 2^WIDTH, borrow
// as an unsigned compare, and signed overflow as a range check on the exact
// signed difference. Directed cases cover the listed corner cases, followed
// by randomized operands.
// Define SERIAL_SUBTRACTOR_OVF_EN for both bench and RTL to exercise ovf.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    int unsigned n_pass;
    int unsigned n_total;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] av, input logic [W-1:0] bv);
        int r;
        r = int'(av) - int'(bv);
        return W'(r);
    endfunction

    function automatic logic ref_bout(input logic [W-1:0] av, input logic [W-1:0] bv);
        return int'(av) < int'(bv);
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] av, input logic [W-1:0] bv);
        int sa;
        int sb;
        int r;
        sa = av[W-1] ? int'(av) - (1 << W) : int'(av);
        sb = bv[W-1] ? int'(bv) - (1 << W) : int'(bv);
        r  = sa - sb;
        return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endfunction

    task automatic check_result(input logic [W-1:0] av, input logic [W-1:0] bv);
        check("diff", 32'(diff), 32'(ref_diff(av, bv)));
        check("bout", 32'(bout), 32'(ref_bout(av, bv)));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check("ovf", 32'(ovf), 32'(ref_ovf(av, bv)));
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_diff"}, 32'(diff), 32'd0);
        check({tag, "_bout"}, 32'(bout), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
`endif
    endtask

    // Present a one-cycle start, then scramble a/b so a late capture shows up.
    // Returns at the negedge of the first cycle after the accepting edge.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    // Called one cycle after an accepting edge; counts cycles (that one = 1)
    // until done is seen, bounded. Optionally pulses start with all-ones
    // operands in cycle mid while the operation is running.
    task automatic wait_done(input int unsigned mid, output int unsigned cycles,
                             output int unsigned busy_cycles);
        cycles      = 1;
        busy_cycles = 0;
        while (!done && cycles < 40) begin
            if (busy) busy_cycles++;
            if (mid != 0 && cycles == mid) begin
                start = 1'b1;
                a     = '1;
                b     = '1;
            end else if (mid != 0 && cycles == mid + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int unsigned mid);
        int unsigned cycles;
        int unsigned busy_cycles;
        launch(av, bv);
        wait_done(mid, cycles, busy_cycles);
        check("done_seen", 32'(done), 32'd1);
        check("latency", cycles, W + 1);
        check("busy_cycles", busy_cycles, W);
        check("busy_in_done", 32'(busy), 32'd0);
        check_result(av, bv);
        @(negedge clk);
        check("done_pulse_len", 32'(done), 32'd0);
        check("diff_hold", 32'(diff), 32'(ref_diff(av, bv)));
    endtask

    task automatic expect_no_done(input string tag, input int unsigned n);
        int unsigned seen;
        seen = 0;
        for (int unsigned i = 0; i < n; i++) begin
            if (done) seen++;
            @(negedge clk);
        end
        check(tag, seen, 0);
    endtask

    initial begin
        int unsigned cycles;
        int unsigned busy_cycles;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Basic directed cases.
        run_op(8'h05, 8'h03, 0);
        run_op(8'h03, 8'h05, 0);
        run_op(8'h00, 8'h00, 0);
        run_op(8'h80, 8'h01, 0);

        // start re-asserted mid-RUN with all-ones operands must be ignored.
        run_op(8'h5A, 8'h3C, 3);
        expect_no_done("extra_done_after_midrun", 12);

        // Reset on the 4th RUN cycle.
        run_op(8'hC3, 8'h21, 0);
        launch(8'h44, 8'h11);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midrun_rst");
        expect_no_done("done_after_rst", 12);
        run_op(8'h44, 8'h11, 0);

        // Back-to-back: start held in the DONE cycle.
        launch(8'h20, 8'h30);
        wait_done(0, cycles, busy_cycles);
        check("b2b_first_done", 32'(done), 32'd1);
        check_result(8'h20, 8'h30);
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h01;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        check("b2b_busy_next", 32'(busy), 32'd1);
        wait_done(0, cycles, busy_cycles);
        check("b2b_gap", cycles, W + 1);
        check_result(8'h10, 8'h01);
        @(negedge clk);
        check("b2b_done_pulse_len", 32'(done), 32'd0);

        // Randomized operands, some with a mid-run start.
        for (int unsigned i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, (i % 4 == 3) ? $urandom_range(W - 1, 1) : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
